axis_img_gen: RTL and testbench
===============================

# axis_img_gen

- AXI4-stream video test-source: on a start pulse, emits one frame of WIDTH×HEIGHT 8-bit pixels in raster order, with tlast on the final pixel.
- Supports optional back-to-back frames.
- Is the producing end of the 8-bit pixel stream that our image filters consume. It drives the filter's slave port, or the S2MM DMA directly, so the receive and write-back path can be exercised without MM2S.

## Interface
- WIDTH, 640, pixels per line (≥2)
- HEIGHT, 480, lines per frame (≥1)
- SQ_LOG2, 3, checkerboard square size = 2^SQ_LOG2 pixels
- aclk  in  1  clock; all logic rising-edge
- areset  in  1  asynchronous, active-high reset
- start  in  1  begin frame (level sampled each cycle)
- continuous  in  1  keep generating frames while high
- mode  in  2  pattern: 0 horizontal ramp, 1 vertical ramp, 2 checkerboard, 3 constant
- const_val  in  8  pixel value for mode 3
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse per completed frame
- m_axis_tready  in  1  sink ready
- m_axis_tdata  out  8  pixel
- m_axis_tkeep  out  1  always 1
- m_axis_tvalid  out  1  beat valid
- m_axis_tlast  out  1  last pixel of frame

## Operation
- States:
  - IDLE → RUN on start==1 in IDLE.
  - RUN → IDLE after the last-pixel handshake, unless the continuous restart below applies.
- Latched at each frame start (including continuous restarts): mode, const_val. Mid-frame changes are ignored.
- Counters:
  - x: 0..WIDTH-1, width clog2(WIDTH).
  - y: 0..HEIGHT-1, width clog2(HEIGHT).
  - Advance only on handshake (tvalid & tready).
  - x wraps to 0 and y increments when x==WIDTH-1.
- Pixel value:
  - mode 0: x[7:0] (truncated, wraps every 256).
  - mode 1: y[7:0].
  - mode 2: 255 if ((x>>SQ_LOG2) ^ (y>>SQ_LOG2)) bit0 == 1, else 0. Pixel (0,0) is 0.
  - mode 3: const_val.
- tlast = 1 exactly when x==WIDTH-1 and y==HEIGHT-1.
- On the last-pixel handshake:
  - If continuous==1, x and y reset to 0 and mode/const_val are relatched; state stays RUN and the next frame's pixel 0 is valid the following cycle (no bubble).
  - Otherwise, go to IDLE.
- done pulses once per frame, including frames within a continuous run.
- start while in RUN is ignored. start in the cycle done is high is accepted, since the state is then IDLE.
- The block never drops or duplicates a beat under any tready pattern.

## Timing
- Reset values: state IDLE, x=y=0, tvalid 0, tlast 0, tdata 0, busy 0, done 0. tkeep is constant 1.
- All outputs are registered; no combinational path from m_axis_tready to any output.
- Frame start:
  - Start sampled high in IDLE at edge N.
  - tvalid=1 with pixel (0,0) from cycle N+1; busy=1 from cycle N+1.
- Frame length: WIDTH·HEIGHT beats. With tready held high, one beat per cycle.
- Handshake:
  - tvalid, once high, stays high until handshake.
  - tdata and tlast are stable while tvalid & !tready.
- Frame end:
  - The last handshake occurs at edge M.
  - done=1 during cycle M+1 only.
  - If not continuing: busy=0 and tvalid=0 from cycle M+1.
- areset mid-frame: outputs return to reset values immediately (asynchronous). No done is produced. The partial frame is abandoned and the next start begins at pixel (0,0).

## Structure
- Package axis_img_pkg: mode encodings (MODE_HRAMP, MODE_VRAMP, MODE_CHECK, MODE_CONST) and the state enum (S_IDLE, S_RUN). The filter blocks share this package.
- Sub-module axis_img_pattern: combinational (mode, x, y, const_val) → pixel, parameterised on SQ_LOG2.
- The top level holds the FSM, counters and output registers.

## Test plan
- WIDTH=4, HEIGHT=2, mode 0, tready=1, one start pulse:
  - Data 0,1,2,3,0,1,2,3 on consecutive cycles; tlast only on beat 8.
  - done one cycle after beat 8; busy low afterwards.
- Same setup, mode 1, tready toggling 1/0 every cycle:
  - Data 0,0,0,0,1,1,1,1.
  - tdata stable through every stall; exactly 8 handshakes.
- WIDTH=16, HEIGHT=16, SQ_LOG2=3, mode 2:
  - Pixels (0,0)=0, (8,0)=255, (0,8)=255, (8,8)=0.
  - 256 beats in total.
- continuous=1 for two frames with mode 3, const_val=0xA5, tready=1:
  - 16 contiguous beats of 0xA5 with no tvalid gap; tlast on beats 8 and 16; two done pulses.
- start held high during RUN:
  - Ignored; exactly one frame of 8 beats is emitted.
  - start still high in the done cycle begins a second frame at the next cycle.
- areset asserted after beat 3:
  - tvalid=0 and busy=0 immediately; no done.
  - The following start emits a full frame starting at pixel (0,0).

Source files
------------

// File: rtl/axis_img_pkg.sv
// Shared types for the 8-bit pixel stream blocks: pattern modes and the
// two-state frame sequencer encoding.
package axis_img_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    MODE_HRAMP = 2'd0,
    MODE_VRAMP = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_CONST = 2'd3
  } img_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } img_state_e;

  // Counter width for a 0..n-1 range; a single-entry range still needs one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_img_gen_if.sv
// AXI4-stream pixel bus: the generator drives the master side, a filter or
// the S2MM DMA sits on the slave side.
interface axis_img_gen_if;
  logic [7:0] tdata;
  logic       tkeep;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_img_pattern.sv
// Combinational pixel pattern: maps a raster coordinate and the latched
// mode/constant onto one 8-bit pixel value.
module axis_img_pattern
  import axis_img_pkg::*;
#(
  parameter int SQ_LOG2 = 3,
  parameter int XW      = 10,
  parameter int YW      = 9
) (
  input  img_mode_e        mode,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic [PIX_W-1:0] const_val,
  output logic [PIX_W-1:0] pixel
);

  logic check;

  // Square parity: bit 0 of the XOR of both coordinates divided by the square size
  assign check = 1'((32'(x) >> SQ_LOG2) ^ (32'(y) >> SQ_LOG2));

  // Ramps use the coordinate truncated (or zero-extended) to 8 bits
  always_comb begin
    pixel = '0;
    unique case (mode)
      MODE_HRAMP: pixel = PIX_W'(x);
      MODE_VRAMP: pixel = PIX_W'(y);
      MODE_CHECK: pixel = check ? 8'hFF : 8'h00;
      MODE_CONST: pixel = const_val;
      default:    pixel = '0;
    endcase
  end

endmodule

// File: rtl/axis_img_gen.sv
// AXI4-stream video test source. A start pulse emits one WIDTH x HEIGHT frame
// in raster order with tlast on the final pixel; with continuous held high the
// next frame follows the last beat without a bubble. Every output is a
// register, so tready never reaches an output combinationally.
module axis_img_gen
  import axis_img_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int SQ_LOG2 = 3
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start,
  input  logic             continuous,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] const_val,
  output logic             busy,
  output logic             done,
  axis_img_gen_if.master   m_axis
);

  localparam int XW = cnt_width(WIDTH);
  localparam int YW = cnt_width(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  img_state_e       state;
  img_state_e       state_next;
  logic [XW-1:0]    x;
  logic [XW-1:0]    x_next;
  logic [YW-1:0]    y;
  logic [YW-1:0]    y_next;
  img_mode_e        mode_q;
  img_mode_e        mode_sel;
  logic [PIX_W-1:0] const_q;
  logic [PIX_W-1:0] const_sel;
  logic [PIX_W-1:0] pixel_next;
  logic [PIX_W-1:0] tdata_q;
  logic             tvalid_q;
  logic             tlast_q;
  logic             busy_q;
  logic             done_q;

  logic handshake;
  logic last_beat;
  logic frame_start;
  logic advance;
  logic finish;

  assign handshake = tvalid_q & m_axis.tready;
  assign last_beat = handshake & tlast_q;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state: start leaves IDLE, a final beat without continuous returns to it
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN:  if (last_beat && !continuous) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Control strobes: load pixel (0,0), step the raster, or wind the frame down
  always_comb begin
    frame_start = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    unique case (state)
      S_IDLE: frame_start = start;
      S_RUN: begin
        if (last_beat) begin
          frame_start = continuous;
          finish      = !continuous;
        end else begin
          advance = handshake;
        end
      end
      default: ;
    endcase
  end

  // Raster position of the beat to be presented next
  always_comb begin
    x_next = x;
    y_next = y;
    if (frame_start || finish) begin
      x_next = '0;
      y_next = '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x_next = '0;
        y_next = y + YW'(1);
      end else begin
        x_next = x + XW'(1);
      end
    end
  end

  // A new frame takes the live mode/constant, otherwise the latched copies hold
  always_comb begin
    mode_sel  = frame_start ? img_mode_e'(mode) : mode_q;
    const_sel = frame_start ? const_val : const_q;
  end

  axis_img_pattern #(
    .SQ_LOG2 (SQ_LOG2),
    .XW      (XW),
    .YW      (YW)
  ) u_pattern (
    .mode      (mode_sel),
    .x         (x_next),
    .y         (y_next),
    .const_val (const_sel),
    .pixel     (pixel_next)
  );

  // Raster counters
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_next;
      y <= y_next;
    end
  end

  // Frame settings are captured once per frame so mid-frame changes are ignored
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mode_q  <= MODE_HRAMP;
      const_q <= '0;
    end else if (frame_start) begin
      mode_q  <= mode_sel;
      const_q <= const_sel;
    end
  end

  // Beat registers only change when a new beat is loaded, which keeps them stable through stalls
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tdata_q <= '0;
      tlast_q <= 1'b0;
    end else if (frame_start || advance) begin
      tdata_q <= pixel_next;
      tlast_q <= (x_next == X_LAST) && (y_next == Y_LAST);
    end else if (finish) begin
      tdata_q <= '0;
      tlast_q <= 1'b0;
    end
  end

  // Status registers follow the sequencer one edge later, matching the beat registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tvalid_q <= (state_next == S_RUN);
      busy_q   <= (state_next == S_RUN);
      done_q   <= last_beat;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = 1'b1;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_axis_img_gen.sv
// Directed bench for axis_img_gen: a 4x2 instance for ramps, back-pressure,
// continuous runs, start handling and reset; a 16x16 instance for the
// checkerboard.
module tb_axis_img_gen;

  logic aclk   = 1'b0;
  logic areset = 1'b1;

  always #5 aclk = ~aclk;

  logic       a_start = 1'b0;
  logic       a_cont  = 1'b0;
  logic [1:0] a_mode  = 2'd0;
  logic [7:0] a_const = 8'd0;
  logic       a_busy;
  logic       a_done;

  logic       b_start = 1'b0;
  logic       b_cont  = 1'b0;
  logic [1:0] b_mode  = 2'd2;
  logic [7:0] b_const = 8'd0;
  logic       b_busy;
  logic       b_done;

  axis_img_gen_if a_if ();
  axis_img_gen_if b_if ();

  axis_img_gen #(.WIDTH(4), .HEIGHT(2), .SQ_LOG2(3)) dut_a (
    .aclk       (aclk),
    .areset     (areset),
    .start      (a_start),
    .continuous (a_cont),
    .mode       (a_mode),
    .const_val  (a_const),
    .busy       (a_busy),
    .done       (a_done),
    .m_axis     (a_if)
  );

  axis_img_gen #(.WIDTH(16), .HEIGHT(16), .SQ_LOG2(3)) dut_b (
    .aclk       (aclk),
    .areset     (areset),
    .start      (b_start),
    .continuous (b_cont),
    .mode       (b_mode),
    .const_val  (b_const),
    .busy       (b_busy),
    .done       (b_done),
    .m_axis     (b_if)
  );

  int tests    = 0;
  int failures = 0;
  int cyc      = 0;

  int a_data[$];
  int a_last[$];
  int a_cyc[$];
  int a_done_cnt  = 0;
  int a_done_cyc  = -1;
  int a_stall_err = 0;
  int a_stall_cnt = 0;
  bit a_prev_stall = 1'b0;
  int a_prev_data  = 0;
  int a_prev_last  = 0;

  int b_data[$];
  int b_last[$];
  int b_cyc[$];
  int b_done_cnt = 0;

  int exp_hramp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_vramp[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Beat monitors, sampled on the falling edge away from the active edge
  always @(negedge aclk) begin
    cyc++;
    if (areset) begin
      a_prev_stall = 1'b0;
    end else begin
      if (a_prev_stall) begin
        if (!(a_if.tvalid && int'(a_if.tdata) == a_prev_data && int'(a_if.tlast) == a_prev_last))
          a_stall_err++;
      end
      if (a_if.tvalid && a_if.tready) begin
        a_data.push_back(int'(a_if.tdata));
        a_last.push_back(int'(a_if.tlast));
        a_cyc.push_back(cyc);
      end
      if (a_done) begin
        a_done_cnt++;
        a_done_cyc = cyc;
      end
      a_prev_stall = a_if.tvalid && !a_if.tready;
      if (a_prev_stall) a_stall_cnt++;
      a_prev_data = int'(a_if.tdata);
      a_prev_last = int'(a_if.tlast);

      if (b_if.tvalid && b_if.tready) begin
        b_data.push_back(int'(b_if.tdata));
        b_last.push_back(int'(b_if.tlast));
        b_cyc.push_back(cyc);
      end
      if (b_done) b_done_cnt++;
    end
  end

  task automatic clearA();
    a_data.delete();
    a_last.delete();
    a_cyc.delete();
    a_done_cnt  = 0;
    a_done_cyc  = -1;
    a_stall_err = 0;
    a_stall_cnt = 0;
  endtask

  // One-cycle start pulse on the 4x2 instance with the given frame settings
  task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] cval, input logic cont);
    @(posedge aclk); #1;
    a_mode  = mode;
    a_const = cval;
    a_cont  = cont;
    a_start = 1'b1;
    @(posedge aclk); #1;
    a_start = 1'b0;
  endtask

  // Waits for `target` done pulses on the selected instance, bounded in cycles
  task automatic waitDone(input bit sel_b, input int target, input int max_cycles,
                          input bit toggle, input string tag);
    int seen = 0;
    int n    = 0;
    while (seen < target && n < max_cycles) begin
      @(posedge aclk); #1;
      n++;
      if (toggle) a_if.tready = ~a_if.tready;
      if (sel_b ? b_done : a_done) seen++;
    end
    checkOutput({tag, "_done_seen"}, seen, target);
  endtask

  function automatic int lastMask(input int n);
    int m = 0;
    for (int i = 0; i < n && i < a_last.size(); i++)
      if (a_last[i] != 0) m |= (1 << i);
    return m;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;

    a_if.tready = 1'b1;
    b_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;

    // Reset values
    checkOutput("rst_tvalid", a_if.tvalid, 0);
    checkOutput("rst_busy",   a_busy,      0);
    checkOutput("rst_done",   a_done,      0);
    checkOutput("rst_tdata",  a_if.tdata,  0);
    checkOutput("rst_tlast",  a_if.tlast,  0);
    checkOutput("rst_tkeep",  a_if.tkeep,  1);
    areset = 1'b0;
    repeat (2) @(posedge aclk);

    // Horizontal ramp, tready high, mode changed mid-frame must be ignored
    clearA();
    applyStimulus(2'd0, 8'h00, 1'b0);
    checkOutput("t1_first_busy",   a_busy,      1);
    checkOutput("t1_first_tvalid", a_if.tvalid, 1);
    checkOutput("t1_first_tdata",  a_if.tdata,  0);
    a_mode  = 2'd3;
    a_const = 8'h11;
    waitDone(1'b0, 1, 40, 1'b0, "t1");
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("t1_beats", a_data.size(), 8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t1_beat%0d", i), (i < a_data.size()) ? a_data[i] : -1, exp_hramp[i]);
    checkOutput("t1_tlast_mask", lastMask(8), 32'h80);
    checkOutput("t1_span", (a_cyc.size() == 8) ? a_cyc[7] - a_cyc[0] : -1, 7);
    checkOutput("t1_done_delay", (a_cyc.size() == 8) ? a_done_cyc - a_cyc[7] : -1, 1);
    checkOutput("t1_done_cnt", a_done_cnt, 1);
    checkOutput("t1_busy_after", a_busy, 0);
    checkOutput("t1_tvalid_after", a_if.tvalid, 0);

    // Vertical ramp with tready toggling every cycle
    clearA();
    applyStimulus(2'd1, 8'h00, 1'b0);
    waitDone(1'b0, 1, 60, 1'b1, "t2");
    a_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("t2_handshakes", a_data.size(), 8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t2_beat%0d", i), (i < a_data.size()) ? a_data[i] : -1, exp_vramp[i]);
    checkOutput("t2_stall_stable", a_stall_err, 0);
    checkOutput("t2_stalls_seen", (a_stall_cnt > 0) ? 1 : 0, 1);
    checkOutput("t2_tlast_mask", lastMask(8), 32'h80);
    checkOutput("t2_done_cnt", a_done_cnt, 1);

    // Checkerboard on the 16x16 instance
    @(posedge aclk); #1;
    b_mode  = 2'd2;
    b_start = 1'b1;
    @(posedge aclk); #1;
    b_start = 1'b0;
    waitDone(1'b1, 1, 400, 1'b0, "t3");
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("t3_beats", b_data.size(), 256);
    if (b_data.size() == 256) begin
      checkOutput("t3_px_0_0",   b_data[0],   0);
      checkOutput("t3_px_7_0",   b_data[7],   0);
      checkOutput("t3_px_8_0",   b_data[8],   255);
      checkOutput("t3_px_0_8",   b_data[128], 255);
      checkOutput("t3_px_8_8",   b_data[136], 0);
      checkOutput("t3_px_15_15", b_data[255], 0);
      checkOutput("t3_last_flag", b_last[255], 1);
      checkOutput("t3_last_early", b_last[254], 0);
      checkOutput("t3_span", b_cyc[255] - b_cyc[0], 255);
    end
    checkOutput("t3_done_cnt", b_done_cnt, 1);

    // Two back-to-back constant frames
    clearA();
    applyStimulus(2'd3, 8'hA5, 1'b1);
    waitDone(1'b0, 1, 40, 1'b0, "t4a");
    a_cont = 1'b0;
    waitDone(1'b0, 1, 40, 1'b0, "t4b");
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("t4_beats", a_data.size(), 16);
    bad = 0;
    foreach (a_data[i]) if (a_data[i] != 8'hA5) bad++;
    checkOutput("t4_non_a5", bad, 0);
    checkOutput("t4_span", (a_cyc.size() == 16) ? a_cyc[15] - a_cyc[0] : -1, 15);
    checkOutput("t4_tlast_mask", lastMask(16), 32'h8080);
    checkOutput("t4_done_cnt", a_done_cnt, 2);
    checkOutput("t4_busy_after", a_busy, 0);

    // start held through a frame, then still high in the done cycle
    clearA();
    @(posedge aclk); #1;
    a_mode  = 2'd0;
    a_start = 1'b1;
    waitDone(1'b0, 1, 40, 1'b0, "t5a");
    checkOutput("t5_beats_first", a_data.size(), 8);
    @(posedge aclk); #1;
    a_start = 1'b0;
    checkOutput("t5_restart_busy",   a_busy,      1);
    checkOutput("t5_restart_tvalid", a_if.tvalid, 1);
    checkOutput("t5_restart_tdata",  a_if.tdata,  0);
    waitDone(1'b0, 1, 40, 1'b0, "t5b");
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("t5_beats_total", a_data.size(), 16);
    checkOutput("t5_done_cnt", a_done_cnt, 2);
    checkOutput("t5_busy_after", a_busy, 0);

    // Asynchronous reset after beat 3, then a clean frame
    clearA();
    applyStimulus(2'd0, 8'h00, 1'b0);
    for (int n = 0; n < 20 && a_data.size() < 3; n++) begin
      @(posedge aclk); #1;
    end
    checkOutput("t6_beats_before_rst", a_data.size(), 3);
    areset = 1'b1;
    #1;
    checkOutput("t6_rst_tvalid", a_if.tvalid, 0);
    checkOutput("t6_rst_busy",   a_busy,      0);
    checkOutput("t6_rst_tdata",  a_if.tdata,  0);
    checkOutput("t6_rst_tlast",  a_if.tlast,  0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    checkOutput("t6_no_done", a_done_cnt, 0);
    checkOutput("t6_idle_after", a_if.tvalid, 0);
    clearA();
    applyStimulus(2'd0, 8'h00, 1'b0);
    waitDone(1'b0, 1, 40, 1'b0, "t6");
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("t6_beats", a_data.size(), 8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t6_beat%0d", i), (i < a_data.size()) ? a_data[i] : -1, exp_hramp[i]);
    checkOutput("t6_tlast_mask", lastMask(8), 32'h80);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
